// File: rtl/cdc_pulse_scheduler.sv
// Source-domain scheduler that shares one toggle pulse synchronizer among NUM_REQ requesters.
// Optional overflow flags are enabled by defining CDC_PULSE_SCHED_OVF_EN.
module cdc_pulse_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MIN_GAP = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic               src_clk,
  input  logic               src_rst_n,
  input  logic               enable,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_pulse,
  output logic               out_pulse,
  output logic [ID_W-1:0]    out_id,
  output logic               busy,
  output logic               pending_any
`ifdef CDC_PULSE_SCHED_OVF_EN
  ,
  output logic [NUM_REQ-1:0] ovf_sticky,
  output logic               ovf_any
`endif
);

  localparam int unsigned GAP_W = $clog2(MIN_GAP);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StGap} state_e;

  state_e             r_state, w_state_d;
  logic [GAP_W-1:0]   r_gap, w_gap_d;
  logic [CNT_W-1:0]   r_cnt [NUM_REQ];
  logic [ID_W-1:0]    r_rr_ptr, r_out_id, w_winner, w_idx, w_ptr_nxt;
  logic               r_out_pulse, w_pending, w_found, w_grant;
  logic [NUM_REQ-1:0] w_dec;

  // Round-robin search starting at r_rr_ptr; first nonzero counter wins.
  always_comb begin
    w_pending = 1'b0;
    w_found   = 1'b0;
    w_winner  = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (r_cnt[w_idx] != '0) begin
        w_pending = 1'b1;
        if (!w_found) begin
          w_found  = 1'b1;
          w_winner = w_idx;
        end
      end
    end
    w_grant = (r_state == StIdle) && enable && !flush && w_pending;
    w_dec   = '0;
    if (w_grant) w_dec[w_winner] = 1'b1;
    w_ptr_nxt = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);
  end

  // GAP lasts MIN_GAP-1 cycles so back-to-back grants land exactly MIN_GAP apart.
  always_comb begin
    w_state_d = r_state;
    w_gap_d   = r_gap;
    unique case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_state_d = StGap;
          w_gap_d   = GAP_W'(MIN_GAP - 2);
        end
      end
      StGap: begin
        if (r_gap == '0) w_state_d = StIdle;
        else             w_gap_d   = r_gap - GAP_W'(1);
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      r_state     <= StIdle;
      r_gap       <= '0;
      r_out_pulse <= 1'b0;
      r_out_id    <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_gap       <= w_gap_d;
      r_out_pulse <= w_grant;
      if (w_grant) begin
        r_out_id <= w_winner;
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  // Simultaneous inc and dec leaves a counter unchanged, even when saturated.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush) begin
          r_cnt[i] <= '0;
        end else if (req_pulse[i] && !w_dec[i] && (r_cnt[i] != CntMax)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else if (!req_pulse[i] && w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

`ifdef CDC_PULSE_SCHED_OVF_EN
  logic [NUM_REQ-1:0] r_ovf, w_ovf_set;

  always_comb begin
    w_ovf_set = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ovf_set[i] = req_pulse[i] && !w_dec[i] && (r_cnt[i] == CntMax);
    end
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n)  r_ovf <= '0;
    else if (flush)  r_ovf <= '0;
    else             r_ovf <= r_ovf | w_ovf_set;
  end

  assign ovf_sticky = r_ovf;
  assign ovf_any    = |r_ovf;
`endif

  assign out_pulse   = r_out_pulse;
  assign out_id      = r_out_id;
  assign pending_any = w_pending;
  assign busy        = w_pending || (r_state == StGap);

endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// Self-checking bench for cdc_pulse_scheduler: directed scenarios plus randomized traffic
// checked against a time-based reference model of pending counts and issue spacing.
module tb_cdc_pulse_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned MIN_GAP = 4;
  localparam int unsigned ID_W    = 2;
  localparam int          CMAX    = 3;

  logic               src_clk = 1'b0;
  logic               src_rst_n;
  logic               enable;
  logic               flush;
  logic [NUM_REQ-1:0] req_pulse;
  logic               out_pulse;
  logic [ID_W-1:0]    out_id;
  logic               busy;
  logic               pending_any;
`ifdef CDC_PULSE_SCHED_OVF_EN
  logic [NUM_REQ-1:0] ovf_sticky;
  logic               ovf_any;
`endif

  cdc_pulse_scheduler #(
    .NUM_REQ(NUM_REQ),
    .CNT_W  (CNT_W),
    .MIN_GAP(MIN_GAP)
  ) dut (
    .src_clk    (src_clk),
    .src_rst_n  (src_rst_n),
    .enable     (enable),
    .flush      (flush),
    .req_pulse  (req_pulse),
    .out_pulse  (out_pulse),
    .out_id     (out_id),
    .busy       (busy),
    .pending_any(pending_any)
`ifdef CDC_PULSE_SCHED_OVF_EN
    ,
    .ovf_sticky (ovf_sticky),
    .ovf_any    (ovf_any)
`endif
  );

  always #5 src_clk = ~src_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending counts, last issue time, round-robin pointer.
  int              m_cnt [NUM_REQ];
  int              m_ptr;
  int              m_last;
  int              m_cyc = 0;
  logic [ID_W-1:0] m_id;
  logic            m_pulse;
`ifdef CDC_PULSE_SCHED_OVF_EN
  logic [NUM_REQ-1:0] m_ovf;
`endif

  function automatic bit m_any();
    for (int i = 0; i < NUM_REQ; i++) if (m_cnt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Busy while anything is pending or the previous issue is younger than MIN_GAP-1 cycles.
  function automatic bit m_busy();
    return m_any() || ((m_cyc - m_last) < (MIN_GAP - 1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    m_ptr   = 0;
    m_last  = m_cyc - 1000;
    m_id    = '0;
    m_pulse = 1'b0;
`ifdef CDC_PULSE_SCHED_OVF_EN
    m_ovf = '0;
`endif
  endtask

  task automatic model_edge(input logic en, input logic fl, input logic [NUM_REQ-1:0] req);
    int w;
    bit g;
    w = -1;
    g = en && !fl && m_any() && ((m_cyc + 1 - m_last) >= MIN_GAP);
    if (g) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w < 0 && m_cnt[(m_ptr + k) % NUM_REQ] > 0) w = (m_ptr + k) % NUM_REQ;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fl) m_cnt[i] = 0;
      else if (g && w == i) m_cnt[i] = m_cnt[i] + int'(req[i]) - 1;
      else if (req[i]) begin
        if (m_cnt[i] == CMAX) begin
`ifdef CDC_PULSE_SCHED_OVF_EN
          m_ovf[i] = 1'b1;
`endif
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
`ifdef CDC_PULSE_SCHED_OVF_EN
    if (fl) m_ovf = '0;
`endif
    m_cyc   = m_cyc + 1;
    m_pulse = g;
    if (g) begin
      m_last = m_cyc;
      m_id   = ID_W'(w);
      m_ptr  = (w + 1) % NUM_REQ;
    end
  endtask

  task automatic step(input logic en, input logic fl, input logic [NUM_REQ-1:0] req);
    enable    = en;
    flush     = fl;
    req_pulse = req;
    @(posedge src_clk);
    model_edge(en, fl, req);
    #1;
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    flush     = 1'b0;
    req_pulse = '0;
    src_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge src_clk);
    #1;
    src_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_pulse !== 1'b0) begin n_err++; $display("FAIL reset_out_pulse got %b want 0", out_pulse); end
    n_cmp++; if (out_id !== '0) begin n_err++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b want 0", pending_any); end
`ifdef CDC_PULSE_SCHED_OVF_EN
    n_cmp++; if (ovf_sticky !== '0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf_sticky); end
`endif
  endtask

  task automatic test_burst();
    int npulse = 0;
    bit exp_p;
    do_reset();
    step(1'b1, 1'b0, 4'b1111);
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 4'b0000);
      exp_p = (k == 1) || (k == 5) || (k == 9) || (k == 13);
      n_cmp++;
      if (out_pulse !== exp_p) begin
        n_err++; $display("FAIL burst_pulse k=%0d got %b want %b", k, out_pulse, exp_p);
      end
      if (exp_p) begin
        n_cmp++;
        if (out_id !== ID_W'((k - 1) / 4)) begin
          n_err++; $display("FAIL burst_id k=%0d got %0d want %0d", k, out_id, (k - 1) / 4);
        end
      end
      if (out_pulse === 1'b1) npulse++;
    end
    n_cmp++; if (npulse != 4) begin n_err++; $display("FAIL burst_count got %0d want 4", npulse); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy_end got %b want 0", busy); end
  endtask

  task automatic test_single_event();
    repeat (3) step(1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 4'b0100);
    n_cmp++; if (out_pulse !== 1'b0) begin n_err++; $display("FAIL single_early got %b want 0", out_pulse); end
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0, 4'b0000);
      n_cmp++;
      if (out_pulse !== (k == 1)) begin
        n_err++; $display("FAIL single_pulse k=%0d got %b want %b", k, out_pulse, (k == 1));
      end
      if (k == 1) begin
        n_cmp++; if (out_id !== 2'd2) begin n_err++; $display("FAIL single_id got %0d want 2", out_id); end
      end
      n_cmp++;
      if (busy !== (k < 4)) begin
        n_err++; $display("FAIL single_busy k=%0d got %b want %b", k, busy, (k < 4));
      end
    end
  endtask

  task automatic test_fairness();
    logic [ID_W-1:0] ids[$];
    int bad = 0;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 1'b0, {(k == 0), 2'b00, 1'b1});
      if (out_pulse === 1'b1) ids.push_back(out_id);
    end
    n_cmp++; if (ids.size() != 6) begin n_err++; $display("FAIL fair_count got %0d want 6", ids.size()); end
    if (ids.size() >= 3) begin
      n_cmp++; if (ids[0] !== 2'd0) begin n_err++; $display("FAIL fair_g0 got %0d want 0", ids[0]); end
      n_cmp++; if (ids[1] !== 2'd3) begin n_err++; $display("FAIL fair_g1 got %0d want 3", ids[1]); end
      for (int i = 2; i < ids.size(); i++) if (ids[i] !== 2'd0) bad++;
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL fair_rest got %0d non-zero ids want 0", bad); end
    end
    step(1'b1, 1'b1, 4'b0000);
    repeat (4) step(1'b1, 1'b0, 4'b0000);
  endtask

  task automatic test_saturation();
    int n1 = 0;
    int nother = 0;
    do_reset();
    repeat (5) step(1'b0, 1'b0, 4'b0010);
    n_cmp++; if (pending_any !== 1'b1) begin n_err++; $display("FAIL sat_pending got %b want 1", pending_any); end
    n_cmp++; if (out_pulse !== 1'b0) begin n_err++; $display("FAIL sat_hold got %b want 0", out_pulse); end
`ifdef CDC_PULSE_SCHED_OVF_EN
    n_cmp++; if (ovf_sticky !== 4'b0010) begin n_err++; $display("FAIL sat_ovf got %b want 0010", ovf_sticky); end
    n_cmp++; if (ovf_any !== 1'b1) begin n_err++; $display("FAIL sat_ovf_any got %b want 1", ovf_any); end
`endif
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 4'b0000);
      if (out_pulse === 1'b1) begin
        if (out_id === 2'd1) n1++;
        else nother++;
      end
    end
    n_cmp++; if (n1 != CMAX) begin n_err++; $display("FAIL sat_count got %0d want %0d", n1, CMAX); end
    n_cmp++; if (nother != 0) begin n_err++; $display("FAIL sat_other_id got %0d want 0", nother); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_busy_end got %b want 0", busy); end
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    int npulse = 0;
    repeat (4) step(1'b0, 1'b0, 4'b0100);
    for (int k = 0; k < 4 && !seen; k++) begin
      step(1'b1, 1'b0, 4'b0000);
      seen = (out_pulse === 1'b1);
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL flush_first_pulse got none want 1"); end
    step(1'b1, 1'b1, 4'b0000);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_gap_busy got %b want 1", busy); end
    n_cmp++; if (pending_any !== 1'b0) begin n_err++; $display("FAIL flush_pending got %b want 0", pending_any); end
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 4'b0000);
      if (out_pulse === 1'b1) npulse++;
    end
    n_cmp++; if (npulse != 0) begin n_err++; $display("FAIL flush_extra got %0d pulses want 0", npulse); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_end got %b want 0", busy); end
`ifdef CDC_PULSE_SCHED_OVF_EN
    n_cmp++; if (ovf_sticky !== '0) begin n_err++; $display("FAIL flush_ovf got %b want 0", ovf_sticky); end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int npulse = 0;
    do_reset();
    repeat (2) step(1'b0, 1'b0, 4'b0110);
    for (int k = 0; k < 4 && !seen; k++) begin
      step(1'b1, 1'b0, 4'b0000);
      seen = (out_pulse === 1'b1);
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_pulse got none want 1"); end
    src_rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (out_pulse !== 1'b0) begin n_err++; $display("FAIL rstmid_out_pulse got %b want 0", out_pulse); end
    n_cmp++; if (out_id !== '0) begin n_err++; $display("FAIL rstmid_out_id got %0d want 0", out_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(posedge src_clk);
    #1;
    src_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 4'b0000);
      if (out_pulse === 1'b1) npulse++;
    end
    n_cmp++; if (npulse != 0) begin n_err++; $display("FAIL rstmid_after got %0d pulses want 0", npulse); end
  endtask

  task automatic test_random();
    logic               en, fl;
    logic [NUM_REQ-1:0] req;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 49) == 0);
      for (int b = 0; b < NUM_REQ; b++) req[b] = ($urandom_range(0, 5) == 0);
      step(en, fl, req);
      n_cmp++;
      if (out_pulse !== m_pulse) begin
        n_err++; $display("FAIL rand_pulse c=%0d got %b want %b", c, out_pulse, m_pulse);
      end
      n_cmp++;
      if (out_id !== m_id) begin
        n_err++; $display("FAIL rand_id c=%0d got %0d want %0d", c, out_id, m_id);
      end
      n_cmp++;
      if (busy !== m_busy()) begin
        n_err++; $display("FAIL rand_busy c=%0d got %b want %b", c, busy, m_busy());
      end
      n_cmp++;
      if (pending_any !== m_any()) begin
        n_err++; $display("FAIL rand_pending c=%0d got %b want %b", c, pending_any, m_any());
      end
`ifdef CDC_PULSE_SCHED_OVF_EN
      n_cmp++;
      if (ovf_sticky !== m_ovf) begin
        n_err++; $display("FAIL rand_ovf c=%0d got %b want %b", c, ovf_sticky, m_ovf);
      end
`endif
    end
  endtask

  initial begin
    src_rst_n = 1'b1;
    enable    = 1'b0;
    flush     = 1'b0;
    req_pulse = '0;
    model_reset();
    test_reset();
    test_burst();
    test_single_event();
    test_fairness();
    test_saturation();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
